// File: rtl/seg7_sched_pkg.sv
// Shared constants and types for the seven-segment display scheduler.
package seg7_sched_pkg;

  localparam int DIGIT_W    = 8;
  localparam int NUM_DIGITS = 8;
  localparam int FRAME_W    = DIGIT_W * NUM_DIGITS;

  // All segments dark: shown while idle and during the gap between sources.
  localparam logic [FRAME_W-1:0] SEG7_BLANK_FRAME = '0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHOW  = 2'd1,
    S_BLANK = 2'd2
  } seg7_state_e;

  // Used to size the shared dwell/blank counter.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/seg7_rr_pick.sv
// Combinational next-source picker: a valid pin wins, otherwise the first
// requester after rr_ptr in circular order. rr_ptr itself is reached last,
// so the current owner only wins when nobody else is asking.
module seg7_rr_pick #(
  parameter int NUM_SRC = 4,
  parameter int SRC_W   = 3
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [SRC_W-1:0]   rr_ptr,
  input  logic               pin_en,
  input  logic [SRC_W-1:0]   pin_src,
  output logic [SRC_W-1:0]   pick,
  output logic               hit,
  output logic               pin_valid
);

  // Pin is honoured only for an in-range index whose source is requesting;
  // out-of-range indices never match any i and so behave like pin_en=0.
  always_comb begin
    pin_valid = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (pin_en && (pin_src == SRC_W'(i)) && req[i]) begin
        pin_valid = 1'b1;
      end
    end
  end

  // Choose the requester with the smallest circular distance past rr_ptr.
  always_comb begin
    int best_d;
    int d;
    pick   = '0;
    hit    = 1'b0;
    best_d = NUM_SRC;
    d      = 0;
    for (int i = 0; i < NUM_SRC; i++) begin
      d = (i + NUM_SRC - 1 - int'(rr_ptr)) % NUM_SRC;
      if (req[i] && (d < best_d)) begin
        best_d = d;
        pick   = SRC_W'(i);
        hit    = 1'b1;
      end
    end
    if (pin_valid) begin
      pick = pin_src;
      hit  = 1'b1;
    end
  end

endmodule

// File: rtl/seg7_display_sched.sv
// Time-shares an 8-digit seven-segment display among NUM_SRC requesters:
// round-robin with a fixed dwell, a blank gap between different sources and
// an optional pin override. All outputs are registered on refresh_clk.
module seg7_display_sched
  import seg7_sched_pkg::*;
#(
  parameter int NUM_SRC     = 4,
  parameter int DWELL_TICKS = 500,
  parameter int BLANK_TICKS = 50,
  parameter int SRC_W       = 3
) (
  input  logic                       refresh_clk,
  input  logic                       rst_n,
  input  logic [NUM_SRC-1:0]         req,
  input  logic [NUM_SRC*FRAME_W-1:0] frame,
  input  logic                       pin_en,
  input  logic [SRC_W-1:0]           pin_src,
  output logic [FRAME_W-1:0]         numbers,
  output logic [NUM_SRC-1:0]         grant,
  output logic [SRC_W-1:0]           active_src,
  output logic                       busy,
  output seg7_state_e                dbg_state
);

  // One counter serves both SHOW dwell and BLANK gap; it restarts on every
  // state change so it never needs to wrap.
  localparam int CNT_W = $clog2(max_int(DWELL_TICKS, BLANK_TICKS)) + 1;
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_TICKS - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_TICKS - 1);

  seg7_state_e         state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SRC_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [FRAME_W-1:0]  numbers_q, numbers_d;
  logic [NUM_SRC-1:0]  grant_q, grant_d;
  logic [SRC_W-1:0]    active_src_q, active_src_d;
  logic                busy_q, busy_d;

  logic [SRC_W-1:0]    pick;
  logic                pick_hit;
  logic                pin_valid;
  logic [FRAME_W-1:0]  pick_frame;
  logic [FRAME_W-1:0]  cur_frame;
  logic [NUM_SRC-1:0]  pick_onehot;
  logic                cur_req;
  logic                other_req;

  seg7_rr_pick #(
    .NUM_SRC (NUM_SRC),
    .SRC_W   (SRC_W)
  ) u_pick (
    .req       (req),
    .rr_ptr    (rr_ptr_q),
    .pin_en    (pin_en),
    .pin_src   (pin_src),
    .pick      (pick),
    .hit       (pick_hit),
    .pin_valid (pin_valid)
  );

  // Frame muxes for the candidate and the on-screen source, plus the
  // one-hot form of the candidate index.
  always_comb begin
    pick_frame  = SEG7_BLANK_FRAME;
    cur_frame   = SEG7_BLANK_FRAME;
    pick_onehot = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (pick == SRC_W'(i)) begin
        pick_frame     = frame[i*FRAME_W +: FRAME_W];
        pick_onehot[i] = 1'b1;
      end
      if (active_src_q == SRC_W'(i)) begin
        cur_frame = frame[i*FRAME_W +: FRAME_W];
      end
    end
  end

  // In SHOW grant_q is one-hot on active_src, so it doubles as a req mask.
  always_comb begin
    cur_req   = |(req & grant_q);
    other_req = |(req & ~grant_q);
  end

  // Next-state and registered-output logic.
  always_comb begin
    logic take_pick;
    logic to_blank;
    state_d      = state_q;
    cnt_d        = cnt_q;
    rr_ptr_d     = rr_ptr_q;
    numbers_d    = numbers_q;
    grant_d      = grant_q;
    active_src_d = active_src_q;
    busy_d       = busy_q;
    take_pick    = 1'b0;
    to_blank     = 1'b0;

    case (state_q)
      S_IDLE: begin
        numbers_d = SEG7_BLANK_FRAME;
        grant_d   = '0;
        busy_d    = 1'b0;
        cnt_d     = '0;
        take_pick = pick_hit;
      end

      S_SHOW: begin
        numbers_d = cur_frame;
        cnt_d     = cnt_q + CNT_W'(1);
        if (!cur_req) begin
          // Owner let go: gap to the next requester, or straight to idle.
          if (|req) begin
            to_blank = 1'b1;
          end else begin
            state_d   = S_IDLE;
            cnt_d     = '0;
            grant_d   = '0;
            numbers_d = SEG7_BLANK_FRAME;
            busy_d    = 1'b0;
          end
        end else if (pin_valid && (pin_src != active_src_q)) begin
          // A pin to another source pre-empts the dwell.
          to_blank = 1'b1;
        end else if (cnt_q == DWELL_LAST) begin
          // pin_valid here can only mean the pin targets the current source.
          if (other_req && !pin_valid) begin
            to_blank = 1'b1;
          end else begin
            cnt_d = '0;
          end
        end
      end

      S_BLANK: begin
        numbers_d = SEG7_BLANK_FRAME;
        grant_d   = '0;
        busy_d    = 1'b1;
        if (cnt_q == BLANK_LAST) begin
          if (pick_hit) begin
            take_pick = 1'b1;
          end else begin
            state_d = S_IDLE;
            cnt_d   = '0;
            busy_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d   = S_IDLE;
        cnt_d     = '0;
        numbers_d = SEG7_BLANK_FRAME;
        grant_d   = '0;
        busy_d    = 1'b0;
      end
    endcase

    if (to_blank) begin
      state_d   = S_BLANK;
      cnt_d     = '0;
      grant_d   = '0;
      numbers_d = SEG7_BLANK_FRAME;
      busy_d    = 1'b1;
    end

    if (take_pick) begin
      state_d      = S_SHOW;
      cnt_d        = '0;
      grant_d      = pick_onehot;
      active_src_d = pick;
      rr_ptr_d     = pick;
      numbers_d    = pick_frame;
      busy_d       = 1'b1;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge refresh_clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      rr_ptr_q     <= SRC_W'(NUM_SRC - 1);
      numbers_q    <= SEG7_BLANK_FRAME;
      grant_q      <= '0;
      active_src_q <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rr_ptr_q     <= rr_ptr_d;
      numbers_q    <= numbers_d;
      grant_q      <= grant_d;
      active_src_q <= active_src_d;
      busy_q       <= busy_d;
    end
  end

  assign numbers    = numbers_q;
  assign grant      = grant_q;
  assign active_src = active_src_q;
  assign busy       = busy_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_seg7_display_sched.sv
// Bench for seg7_display_sched: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_seg7_display_sched;

  localparam int N     = 4;
  localparam int DWELL = 4;
  localparam int BLANK = 2;

  logic          refresh_clk;
  logic          rst_n;
  logic [N-1:0]  req;
  logic [63:0]   frm [N];
  logic [N*64-1:0] frame;
  logic          pin_en;
  logic [2:0]    pin_src;
  logic [63:0]   numbers;
  logic [N-1:0]  grant;
  logic [2:0]    active_src;
  logic          busy;
  logic [1:0]    dbg_state;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  assign frame = {frm[3], frm[2], frm[1], frm[0]};

  seg7_display_sched #(
    .NUM_SRC     (N),
    .DWELL_TICKS (DWELL),
    .BLANK_TICKS (BLANK),
    .SRC_W       (3)
  ) dut (
    .refresh_clk (refresh_clk),
    .rst_n       (rst_n),
    .req         (req),
    .frame       (frame),
    .pin_en      (pin_en),
    .pin_src     (pin_src),
    .numbers     (numbers),
    .grant       (grant),
    .active_src  (active_src),
    .busy        (busy),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock ----------------
  initial begin
    refresh_clk = 1'b0;
    forever #5 refresh_clk = ~refresh_clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish, expected finish before 2ms");
    $fatal(1, "timeout");
  end

  // ---------------- behavioural model ----------------
  // mode: 0 idle, 1 showing m_src, 2 blank gap. m_age = edges spent so far.
  int          m_mode, m_src, m_age, m_last;
  logic [63:0] exp_numbers;
  logic [N-1:0] exp_grant;
  int          exp_active;
  bit          exp_busy;

  function automatic bit req_has(input logic [N-1:0] r, input int s);
    return ((r >> s) & N'(1)) != '0;
  endfunction

  function automatic int model_pick(input logic [N-1:0] r, input int last,
                                    input bit pen, input int psrc);
    if (pen && psrc < N && req_has(r, psrc)) return psrc;
    for (int k = 1; k <= N; k++) begin
      if (req_has(r, (last + k) % N)) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic model_step();
    int  p;
    bit  pv;
    if (!rst_n) begin
      m_mode = 0; m_src = 0; m_age = 0; m_last = N - 1;
    end else begin
      pv = pin_en && (int'(pin_src) < N) && req_has(req, int'(pin_src));
      p  = model_pick(req, m_last, pin_en, int'(pin_src));
      case (m_mode)
        0: if (p >= 0) begin m_mode = 1; m_src = p; m_last = p; m_age = 0; end
        1: begin
          if (!req_has(req, m_src)) begin
            m_mode = (req != '0) ? 2 : 0; m_age = 0;
          end else if (pv && int'(pin_src) != m_src) begin
            m_mode = 2; m_age = 0;
          end else if (m_age == DWELL - 1) begin
            if ((req & ~(N'(1) << m_src)) != '0 && !pv) m_mode = 2;
            m_age = 0;
          end else begin
            m_age++;
          end
        end
        default: begin
          if (m_age == BLANK - 1) begin
            m_age = 0;
            if (p >= 0) begin m_mode = 1; m_src = p; m_last = p; end
            else m_mode = 0;
          end else begin
            m_age++;
          end
        end
      endcase
    end
    exp_numbers = (m_mode == 1) ? frm[m_src] : 64'h0;
    exp_grant   = (m_mode == 1) ? (N'(1) << m_src) : '0;
    exp_busy    = (m_mode != 0);
    exp_active  = m_src;
  endtask

  initial begin
    m_mode = 0; m_src = 0; m_age = 0; m_last = N - 1;
    forever begin
      @(posedge refresh_clk);
      model_step();
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, on the falling edge.
  initial begin
    forever begin
      @(negedge refresh_clk);
      if (chk_on) begin
        chk("m_numbers", numbers, exp_numbers);
        chk("m_grant", 64'(grant), 64'(exp_grant));
        chk("m_active", 64'(active_src), 64'(exp_active));
        chk("m_busy", 64'(busy), 64'(exp_busy));
        chk("m_state", 64'(dbg_state), 64'(m_mode));
      end
    end
  end

  // ---------------- driver ----------------
  task automatic step(input int n);
    repeat (n) @(negedge refresh_clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
  endtask

  logic [N-1:0] seq2 [13];
  logic [N-1:0] seq5 [6];

  initial begin
    seq2 = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000,
             4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0001};
    seq5 = '{4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b0001};

    rst_n   = 1'b0;
    req     = '0;
    pin_en  = 1'b0;
    pin_src = '0;
    frm[0]  = 64'h0102030405060708;
    frm[1]  = 64'h00000000000000FF;
    frm[2]  = 64'hA5A5A5A5A5A5A5A5;
    frm[3]  = 64'h123456789ABCDEF0;
    step(2);
    chk_on = 1'b1;
    chk("rst_numbers", numbers, 64'h0);
    chk("rst_grant", 64'(grant), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_active", 64'(active_src), 64'h0);

    // Sole requester: shown after one edge, then re-dwells with no blank.
    rst_n = 1'b1;
    req   = 4'b0001;
    step(1);
    chk("solo_numbers", numbers, 64'h0102030405060708);
    chk("solo_grant", 64'(grant), 64'h1);
    chk("solo_busy", 64'(busy), 64'h1);
    for (int i = 0; i < 12; i++) begin
      step(1);
      chk("solo_hold", 64'(grant), 64'h1);
    end

    // Two requesters alternate with a two-cycle gap.
    do_reset();
    req = 4'b0101;
    for (int i = 0; i < 13; i++) begin
      step(1);
      chk("rr_grant", 64'(grant), 64'(seq2[i]));
    end

    // Owner drops with nobody else waiting: straight to idle.
    req = 4'b0000;
    step(1);
    chk("drop_idle_busy", 64'(busy), 64'h0);
    chk("drop_idle_grant", 64'(grant), 64'h0);
    chk("drop_idle_numbers", numbers, 64'h0);

    // Owner drops while src1 waits: blank then src1; live frame updates.
    do_reset();
    req = 4'b0001;
    step(1);
    req = 4'b0010;
    step(1);
    chk("drop_blank_grant", 64'(grant), 64'h0);
    chk("drop_blank_busy", 64'(busy), 64'h1);
    step(1);
    chk("drop_blank2_grant", 64'(grant), 64'h0);
    step(1);
    chk("drop_next_grant", 64'(grant), 64'h2);
    chk("drop_next_numbers", numbers, 64'hFF);
    frm[1] = 64'h3F;
    step(1);
    chk("live_frame", numbers, 64'h3F);
    frm[0] = 64'hDEADBEEFCAFEF00D;
    step(1);
    chk("other_frame", numbers, 64'h3F);

    // Reset in the middle of a gap, then lowest requester wins.
    req = 4'b1100;
    step(1);
    chk("gap_busy", 64'(busy), 64'h1);
    rst_n = 1'b0;
    step(1);
    chk("midrst_numbers", numbers, 64'h0);
    chk("midrst_grant", 64'(grant), 64'h0);
    chk("midrst_busy", 64'(busy), 64'h0);
    chk("midrst_active", 64'(active_src), 64'h0);
    rst_n = 1'b1;
    step(1);
    chk("post_rst_grant", 64'(grant), 64'h4);
    chk("post_rst_active", 64'(active_src), 64'h2);
    chk("post_rst_numbers", numbers, 64'hA5A5A5A5A5A5A5A5);

    // Pin pre-empts mid-dwell, holds across dwells, release resumes rotation.
    do_reset();
    req = 4'b0001;
    step(2);
    pin_en  = 1'b1;
    pin_src = 3'd3;
    req     = 4'b1001;
    step(1);
    chk("pin_preempt", 64'(grant), 64'h0);
    step(1);
    chk("pin_gap", 64'(grant), 64'h0);
    step(1);
    chk("pin_grant", 64'(grant), 64'h8);
    chk("pin_numbers", numbers, 64'h123456789ABCDEF0);
    for (int i = 0; i < 20; i++) begin
      step(1);
      chk("pin_hold", 64'(grant), 64'h8);
    end
    pin_en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      chk("unpin_grant", 64'(grant), 64'(seq5[i]));
    end

    // Randomized traffic; the per-cycle model check does the work.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) req = N'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) pin_en = ~pin_en;
      if ($urandom_range(0, 7) == 0) pin_src = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) frm[$urandom_range(0, N-1)] = {$urandom, $urandom};
      rst_n = ($urandom_range(0, 199) != 0);
      step(1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
